// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and data width.
// Used by both the receiver and the transmitter of the UART path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer. Both flops reset to 1 so an idle-high
// line does not produce a spurious edge when reset is released.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB-first, optional parity, 1 stop.
// CLKDIV is the bit period minus one in CLK cycles, latched at frame start.
// Build option: define UART_RX_PARITY_EN to add a parity bit to the frame
// (even parity; additionally define UART_RX_PARITY_ODD for odd parity).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                   CLK,
  input  logic                   SRSTN,
  input  logic [DIV_W-1:0]       CLKDIV,
  input  logic                   RX,
  output logic [UART_DATA_W-1:0] DATA,
  output logic                   DONE,
  output logic                   FRAME_ERR,
  output logic                   PARITY_ERR,
  output logic                   BUSY
);

`ifdef UART_RX_PARITY_ODD
  localparam logic PAR_ODD = 1'b1;
`else
  localparam logic PAR_ODD = 1'b0;
`endif

  logic rx_sync;
  logic fall;
  logic cnt_zero;

  uart_rx_state_t          state_q, state_d;
  logic                    rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [UART_DATA_W-1:0]  shift_q, shift_d;
  logic [UART_DATA_W-1:0]  data_q, data_d;
  logic                    done_q, done_d;
  logic                    ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                    perr_q, perr_d;
  logic                    par_bad_q, par_bad_d;
`endif

  sync_2ff u_sync (
    .clk   (CLK),
    .rst_n (SRSTN),
    .d     (RX),
    .q     (rx_sync)
  );

  // Start of frame is a synced-low sample whose predecessor was high.
  assign fall     = rx_prev_q & ~rx_sync;
  assign cnt_zero = (cnt_q == '0);

  // State register and datapath flops; status pulses live for one cycle.
  always_ff @(posedge CLK or negedge SRSTN) begin
    if (!SRSTN) begin
      state_q   <= RX_IDLE;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state and datapath update: count down to each mid-bit sample point.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    rx_prev_d = rx_sync;
    div_d     = div_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          div_d   = CLKDIV;
          cnt_d   = CLKDIV >> 1;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (rx_sync) begin
          // Line back high at mid start bit: treat as a glitch.
          state_d = RX_IDLE;
        end else begin
          cnt_d   = div_q;
          idx_d   = '0;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          shift_d[idx_q] = rx_sync;
          cnt_d          = div_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          par_bad_d = rx_sync ^ (^shift_q) ^ PAR_ODD;
          cnt_d     = div_q;
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          data_d  = shift_q;
          state_d = RX_IDLE;
          // A low stop bit reports framing only, even if parity also failed.
          if (!rx_sync) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: registered status and data, busy decoded from state.
  always_comb begin
    DATA      = data_q;
    DONE      = done_q;
    FRAME_ERR = ferr_q;
`ifdef UART_RX_PARITY_EN
    PARITY_ERR = perr_q;
`else
    PARITY_ERR = 1'b0;
`endif
    BUSY      = (state_q != RX_IDLE);
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner
// sequences (false start, break, mid-frame reset) and random frames judged by
// a frame-level outcome model.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
`ifdef UART_RX_PARITY_ODD
  localparam bit PAR_ODD = 1'b1;
`else
  localparam bit PAR_ODD = 1'b0;
`endif

  localparam int EV_DONE   = 0;
  localparam int EV_FRAME  = 1;
  localparam int EV_PARITY = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         par_flip;
    int         div;
    int         exp_kind;
  } vec_t;

  logic        clk;
  logic        srstn;
  logic [15:0] clkdiv;
  logic        rx;
  logic [7:0]  data;
  logic        done;
  logic        frame_err;
  logic        parity_err;
  logic        busy;

  int   n_total;
  int   n_pass;
  int   busy_cycles;
  ev_t  ev_q[$];
  vec_t vecs[$];

  uart_rx #(.DIV_W(16)) dut (
    .CLK        (clk),
    .SRSTN      (srstn),
    .CLKDIV     (clkdiv),
    .RX         (rx),
    .DATA       (data),
    .DONE       (done),
    .FRAME_ERR  (frame_err),
    .PARITY_ERR (parity_err),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every status pulse (one entry per high cycle) and busy time.
  always @(negedge clk) begin
    if (srstn) begin
      if (done)       ev_q.push_back('{EV_DONE, data});
      if (frame_err)  ev_q.push_back('{EV_FRAME, data});
      if (parity_err) ev_q.push_back('{EV_PARITY, data});
      if (busy)       busy_cycles++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Frame outcome from the frame's own rules, not from any receiver internals.
  function automatic int model_kind(input bit stop, input bit par_flip);
    if (!stop) return EV_FRAME;
    if (PAR_EN && par_flip) return EV_PARITY;
    return EV_DONE;
  endfunction

  function automatic bit par_bit(input logic [7:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  task automatic drive_bit(input bit b, input int div);
    rx = b;
    repeat (div + 1) @(negedge clk);
  endtask

  // Serialize one frame the way uart_tx would, then idle for two bit times.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                            input int div, input int extra_low);
    clkdiv = 16'(div);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (PAR_EN) drive_bit(par_bit(d) ^ par_flip, div);
    drive_bit(stop, div);
    if (!stop) repeat (extra_low * (div + 1)) @(negedge clk);
    rx = 1'b1;
    repeat (5 + 2 * (div + 1)) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int kind, input logic [7:0] d);
    ev_t ev;
    check({name, " pulse count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      ev = ev_q.pop_front();
      check({name, " pulse kind"}, ev.kind, kind);
      check({name, " pulse data"}, ev.data, d);
    end
    check({name, " DATA held"}, data, d);
    ev_q.delete();
  endtask

  initial begin
    logic [7:0] rd;
    int         rdiv;
    bit         rstop;
    bit         rflip;

    n_total = 0;
    n_pass  = 0;
    busy_cycles = 0;
    srstn  = 1'b0;
    rx     = 1'b1;
    clkdiv = 16'd867;
    repeat (5) @(negedge clk);
    srstn = 1'b1;

    // Reset state after a long idle-high line.
    repeat (1000) @(negedge clk);
    check("reset DATA", data, 8'h00);
    check("reset DONE", done, 1'b0);
    check("reset FRAME_ERR", frame_err, 1'b0);
    check("reset PARITY_ERR", parity_err, 1'b0);
    check("reset BUSY", busy, 1'b0);
    check("idle pulses", ev_q.size(), 0);

    // Directed frame table: loopback pair first, then boundary data values.
    vecs.push_back('{8'hAB, 1'b1, 1'b0, 867, EV_DONE});
    vecs.push_back('{8'h0F, 1'b1, 1'b0, 867, EV_DONE});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 15,  EV_DONE});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 15,  EV_DONE});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 11,  EV_DONE});
    vecs.push_back('{8'h01, 1'b0, 1'b0, 20,  EV_FRAME});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 15, EV_DONE});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 15, EV_PARITY});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 15, EV_FRAME});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip, vecs[i].div, 0);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].data);
    end

    // False start: 200-cycle low pulse, busy only for the half-bit wait.
    clkdiv = 16'd867;
    busy_cycles = 0;
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (600) @(negedge clk);
    check("false start pulses", ev_q.size(), 0);
    check("false start busy cycles", busy_cycles, 434);
    check("false start BUSY after", busy, 1'b0);
    ev_q.delete();

    // Break: low stop bit held two more bit times, then line high.
    send_frame(8'h55, 1'b0, 1'b0, 99, 2);
    check_frame("break", EV_FRAME, 8'h55);
    repeat (300) @(negedge clk);
    check("break no second frame", ev_q.size(), 0);
    check("break BUSY idle", busy, 1'b0);

    // Reset midway through data bit 4 of 0xC3.
    clkdiv = 16'd99;
    rd = 8'hC3;
    drive_bit(1'b0, 99);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], 99);
    rx = rd[4];
    repeat (50) @(negedge clk);
    srstn = 1'b0;
    #1;
    check("midreset DATA", data, 8'h00);
    check("midreset BUSY", busy, 1'b0);
    check("midreset DONE", done, 1'b0);
    check("midreset FRAME_ERR", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    srstn = 1'b1;
    repeat (300) @(negedge clk);
    check("midreset no pulse", ev_q.size(), 0);
    ev_q.delete();
    send_frame(8'h3C, 1'b1, 1'b0, 99, 0);
    check_frame("after reset", EV_DONE, 8'h3C);

    // Random frames judged by the outcome model.
    for (int i = 0; i < 24; i++) begin
      rd    = 8'($urandom);
      rdiv  = int'($urandom_range(40, 11));
      rstop = ($urandom_range(3, 0) != 0);
      rflip = PAR_EN ? bit'($urandom_range(1, 0)) : 1'b0;
      send_frame(rd, rstop, rflip, rdiv, 0);
      check_frame($sformatf("rand%0d", i), model_kind(rstop, rflip), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_uart_rx
